// File: rtl/fetch_insn_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_insn_queue
// Purpose  : Circular instruction queue between fetch and decode. Fetch pushes
//            one instruction (plus PC and branch-prediction payload) per
//            cycle; the decoder sees the head entry combinationally and pops
//            it when consumed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   flush               : discard all entries (redirect / mispredict)
//   push                : offer one instruction this cycle
//   insn_in, pc_in,
//   pred_in, pht_idx_in,
//   pred_target_in      : payload of the offered instruction
//   pop                 : decoder consumes the head entry
//   valid               : head entry present (count != 0)
//   insn, pc, insn_pred,
//   pht_idx,
//   insn_pred_target    : head payload, zero while valid=0
//   full, almost_full   : count == DEPTH, count >= DEPTH-2
//   count               : occupancy
//   overflow            : sticky, set when a push arrives while full
// Optional feature
//   FETCHQ_CYCLE_ACCOUNTING_EN : adds fetch_cycle_in / fetch_cycle, a 64-bit
//                                cycle stamp carried alongside each entry.
// ============================================================================

`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif

module fetch_insn_queue #(
    parameter int LG_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [31:0]           insn_in,
    input  logic [`M_WIDTH-1:0]   pc_in,
    input  logic [0:0]            pred_in,
    input  logic [`LG_PHT_SZ-1:0] pht_idx_in,
    input  logic [`M_WIDTH-1:0]   pred_target_in,
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
    input  logic [63:0]           fetch_cycle_in,
    output logic [63:0]           fetch_cycle,
`endif
    output logic                  full,
    output logic                  almost_full,
    input  logic                  pop,
    output logic                  valid,
    output logic [31:0]           insn,
    output logic [`M_WIDTH-1:0]   pc,
    output logic [0:0]            insn_pred,
    output logic [`LG_PHT_SZ-1:0] pht_idx,
    output logic [`M_WIDTH-1:0]   insn_pred_target,
    output logic [LG_DEPTH:0]     count,
    output logic                  overflow
);

    localparam int                DEPTH       = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] C_DEPTH     = (LG_DEPTH+1)'(DEPTH);
    localparam logic [LG_DEPTH:0] C_AF_LEVEL  = (LG_DEPTH+1)'(DEPTH - 2);
    localparam logic [LG_DEPTH:0] C_PTR_ONE   = (LG_DEPTH+1)'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // and the occupancy is a plain modular difference.
    logic [LG_DEPTH:0] head_q, head_d;
    logic [LG_DEPTH:0] tail_q, tail_d;
    logic              overflow_q, overflow_d;

    logic [31:0]           insn_mem_q   [DEPTH];
    logic [`M_WIDTH-1:0]   pc_mem_q     [DEPTH];
    logic [0:0]            pred_mem_q   [DEPTH];
    logic [`LG_PHT_SZ-1:0] pht_mem_q    [DEPTH];
    logic [`M_WIDTH-1:0]   target_mem_q [DEPTH];
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
    logic [63:0]           cycle_mem_q  [DEPTH];
`endif

    logic                w_push_acc;
    logic                w_pop_acc;
    logic [LG_DEPTH-1:0] w_head_idx;
    logic [LG_DEPTH-1:0] w_tail_idx;

    // Status derives only from the registered pointers.
    assign count       = tail_q - head_q;
    assign valid       = (count != '0);
    assign full        = (count == C_DEPTH);
    assign almost_full = (count >= C_AF_LEVEL);
    assign overflow    = overflow_q;

    assign w_push_acc = push & ~full  & ~flush;
    assign w_pop_acc  = pop  & valid  & ~flush;
    assign w_head_idx = head_q[LG_DEPTH-1:0];
    assign w_tail_idx = tail_q[LG_DEPTH-1:0];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;
        // A push against a full queue is an error whatever else happens.
        if (push && full) begin
            overflow_d = 1'b1;
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (w_push_acc) begin
                tail_d = tail_q + C_PTR_ONE;
            end
            if (w_pop_acc) begin
                head_d = head_q + C_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage is deliberately not reset; valid gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            insn_mem_q[w_tail_idx]   <= insn_in;
            pc_mem_q[w_tail_idx]     <= pc_in;
            pred_mem_q[w_tail_idx]   <= pred_in;
            pht_mem_q[w_tail_idx]    <= pht_idx_in;
            target_mem_q[w_tail_idx] <= pred_target_in;
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
            cycle_mem_q[w_tail_idx]  <= fetch_cycle_in;
`endif
        end
    end

    // Zero-latency head presentation, forced to zero when empty.
    assign insn             = valid ? insn_mem_q[w_head_idx]   : '0;
    assign pc               = valid ? pc_mem_q[w_head_idx]     : '0;
    assign insn_pred        = valid ? pred_mem_q[w_head_idx]   : '0;
    assign pht_idx          = valid ? pht_mem_q[w_head_idx]    : '0;
    assign insn_pred_target = valid ? target_mem_q[w_head_idx] : '0;
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
    assign fetch_cycle      = valid ? cycle_mem_q[w_head_idx]  : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_insn_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_insn_queue
// Purpose  : Self-checking bench for fetch_insn_queue. A queue-based reference
//            model tracks expected contents; a negedge monitor compares the
//            DUT head/status against it. Directed scenarios are followed by a
//            randomized phase.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif

module tb_fetch_insn_queue;

    localparam int MW    = `M_WIDTH;
    localparam int PW    = `LG_PHT_SZ;
    localparam int LGD   = 3;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0]   insn;
        logic [MW-1:0] pc;
        logic [0:0]    pred;
        logic [PW-1:0] pht;
        logic [MW-1:0] tgt;
        logic [63:0]   cyc;
    } item_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush = 1'b0;
    logic           push = 1'b0;
    logic           pop = 1'b0;
    logic [31:0]    insn_in = '0;
    logic [MW-1:0]  pc_in = '0;
    logic [0:0]     pred_in = '0;
    logic [PW-1:0]  pht_idx_in = '0;
    logic [MW-1:0]  pred_target_in = '0;
    logic [63:0]    fetch_cycle_in = '0;

    logic           full, almost_full, valid, overflow;
    logic [31:0]    insn;
    logic [MW-1:0]  pc;
    logic [0:0]     insn_pred;
    logic [PW-1:0]  pht_idx;
    logic [MW-1:0]  insn_pred_target;
    logic [LGD:0]   count;
    logic [63:0]    fetch_cycle;

    int tests = 0;
    int fails = 0;

    item_t exp_q[$];
    bit    m_ovf = 1'b0;

    fetch_insn_queue #(.LG_DEPTH(LGD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .push             (push),
        .insn_in          (insn_in),
        .pc_in            (pc_in),
        .pred_in          (pred_in),
        .pht_idx_in       (pht_idx_in),
        .pred_target_in   (pred_target_in),
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
        .fetch_cycle_in   (fetch_cycle_in),
        .fetch_cycle      (fetch_cycle),
`endif
        .full             (full),
        .almost_full      (almost_full),
        .pop              (pop),
        .valid            (valid),
        .insn             (insn),
        .pc               (pc),
        .insn_pred        (insn_pred),
        .pht_idx          (pht_idx),
        .insn_pred_target (insn_pred_target),
        .count            (count),
        .overflow         (overflow)
    );

`ifndef FETCHQ_CYCLE_ACCOUNTING_EN
    assign fetch_cycle = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a FIFO of items following the queue's acceptance rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            int  sz;
            item_t it;
            sz = exp_q.size();
            if (push && sz == DEPTH) m_ovf = 1'b1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pop && sz != 0) void'(exp_q.pop_front());
                if (push && sz != DEPTH) begin
                    it.insn = insn_in;
                    it.pc   = pc_in;
                    it.pred = pred_in;
                    it.pht  = pht_idx_in;
                    it.tgt  = pred_target_in;
`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
                    it.cyc  = fetch_cycle_in;
`else
                    it.cyc  = '0;
`endif
                    exp_q.push_back(it);
                end
            end
        end
    end

    // Monitor: compares presented head and status against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            int sz;
            sz = exp_q.size();
            chk("mon_count", 64'(count), 64'(sz));
            chk("mon_valid", 64'(valid), 64'(sz != 0));
            chk("mon_full", 64'(full), 64'(sz == DEPTH));
            chk("mon_almost_full", 64'(almost_full), 64'(sz >= DEPTH - 2));
            chk("mon_overflow", 64'(overflow), 64'(m_ovf));
            if (sz != 0) begin
                chk("mon_insn", 64'(insn), 64'(exp_q[0].insn));
                chk("mon_pc", 64'(pc), 64'(exp_q[0].pc));
                chk("mon_pred", 64'(insn_pred), 64'(exp_q[0].pred));
                chk("mon_pht", 64'(pht_idx), 64'(exp_q[0].pht));
                chk("mon_target", 64'(insn_pred_target), 64'(exp_q[0].tgt));
                chk("mon_cycle", fetch_cycle, exp_q[0].cyc);
            end else begin
                chk("mon_empty_payload",
                    64'(insn) | 64'(pc) | 64'(insn_pred) | 64'(pht_idx) |
                    64'(insn_pred_target) | fetch_cycle, 64'h0);
            end
        end
    end

    task automatic drive(input bit pu, input bit po, input bit fl,
                         input logic [31:0] iv, input logic [MW-1:0] pv,
                         input logic [63:0] cv);
        push           = pu;
        pop            = po;
        flush          = fl;
        insn_in        = iv;
        pc_in          = pv;
        pred_in        = iv[0];
        pht_idx_in     = PW'(iv);
        pred_target_in = pv + MW'(8);
        fetch_cycle_in = cv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 64'h0);
    endtask

    initial begin
        logic [MW-1:0] next_pc;

        // Reset state
        #3;
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_almost_full", 64'(almost_full), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        chk("rst_insn", 64'(insn), 64'h0);
        #9 reset_n = 1'b1;
        step();

        // Single push: visible one cycle later
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0013, MW'('h1000), 64'h1);
        #1 chk("push0_valid_same_cycle", 64'(valid), 64'h0);
        step();
        idle();
        chk("push0_valid", 64'(valid), 64'h1);
        chk("push0_insn", 64'(insn), 64'h13);
        chk("push0_pc", 64'(pc), 64'h1000);
        chk("push0_count", 64'(count), 64'h1);

        // Fill to full, tracking almost_full
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), MW'('h1000 + 4 * i), 64'(i + 1));
            step();
            chk("fill_count", 64'(count), 64'(i + 1));
            chk("fill_almost_full", 64'(almost_full), 64'(i + 1 >= 6));
        end
        chk("fill_full", 64'(full), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD, MW'('h5000), 64'h0);
        step();
        chk("ovf_set", 64'(overflow), 64'h1);
        chk("ovf_head_pc", 64'(pc), 64'h1000);
        chk("ovf_count", 64'(count), 64'h8);

        // Push and pop together while full: push dropped, pop taken
        drive(1'b1, 1'b1, 1'b0, 32'hBEEF, MW'('h6000), 64'h0);
        step();
        chk("fullpp_count", 64'(count), 64'h7);
        chk("fullpp_overflow", 64'(overflow), 64'h1);
        chk("fullpp_head_pc", 64'(pc), 64'h1004);

        // Drain
        drive(1'b0, 1'b1, 1'b0, 32'h0, '0, 64'h0);
        repeat (7) step();
        idle();
        chk("drain_valid", 64'(valid), 64'h0);

        // Steady state at count=3 across the pointer wrap
        next_pc = MW'('h2000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i), next_pc, 64'(i));
            next_pc += MW'(4);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h300 + 32'(i), next_pc, 64'(i));
            next_pc += MW'(4);
            step();
            chk("wrap_count", 64'(count), 64'h3);
            chk("wrap_head_pc", 64'(pc), 64'('h2000 + 4 * (i + 1)));
        end

        // Flush overrides push and pop
        drive(1'b0, 1'b0, 1'b1, 32'h0, '0, 64'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h400 + 32'(i), MW'('h3000 + 4 * i), 64'(i));
            step();
        end
        chk("preflush_count", 64'(count), 64'h5);
        drive(1'b1, 1'b1, 1'b1, 32'h777, MW'('h7000), 64'h0);
        step();
        idle();
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_valid", 64'(valid), 64'h0);
        chk("flush_payload", 64'(insn) | 64'(pc) | 64'(insn_pred) | 64'(pht_idx) |
            64'(insn_pred_target) | fetch_cycle, 64'h0);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h500 + 32'(i), MW'('h4000 + 4 * i), 64'(i));
            step();
        end
        idle();
        chk("prerst_count", 64'(count), 64'h4);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(valid), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_overflow", 64'(overflow), 64'h0);
        #1 reset_n = 1'b1;
        step();
        chk("postrst_count", 64'(count), 64'h0);

`ifdef FETCHQ_CYCLE_ACCOUNTING_EN
        drive(1'b1, 1'b0, 1'b0, 32'h600, MW'('h8000), 64'h2A);
        step();
        idle();
        chk("cycle_head", fetch_cycle, 64'h2A);
        drive(1'b0, 1'b1, 1'b0, 32'h0, '0, 64'h0);
        step();
        idle();
        chk("cycle_empty", fetch_cycle, 64'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 3), $urandom,
                  MW'({$urandom, $urandom}), {$urandom, $urandom});
            step();
        end
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
